md_lr_force_drain: RTL and testbench
====================================

Name: md_lr_force_drain

Overview:
- Sits directly downstream of the md_lr_top force interface (fready/fvalid/faddr/flast/fdata) inside the AFU.
- Buffers force results in a small FIFO.
- Presents each 96-bit force entry to the host CSR path as 16-bit slices, one slice per acknowledge.
- Tracks completion (flast drained) and counts accepted forces, so software can poll without losing results.

Parameters:
- PADDRW, 15: width of force/particle address.
- FDATAW, 96: width of force data (3 x 32-bit FP).
- SLICEW, 16: width of one host-visible slice; FDATAW must be a multiple of SLICEW.
- DEPTH, 16: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fready  out  1  ready to accept force entry (to md_lr_top)
- fvalid  in  1  force entry valid (from md_lr_top)
- faddr  in  PADDRW  particle address of force
- flast  in  1  last force of run
- fdata  in  FDATAW  force data
- rd_valid  out  1  head entry available
- rd_slice  out  SLICEW  current slice of head fdata
- rd_idx  out  clog2(FDATAW/SLICEW)  index of current slice
- rd_addr  out  PADDRW  faddr of head entry
- rd_last  out  1  flast of head entry
- slice_ack  in  1  single-cycle pulse: consume current slice
- clr_done  in  1  single-cycle pulse: clear done and nforce
- done  out  1  sticky: entry with flast=1 fully drained
- nforce  out  PADDRW+1  forces accepted since reset/clr_done
- level  out  clog2(DEPTH)+1  FIFO occupancy
- csum  out  FDATAW  running XOR of accepted fdata (see Optional Feature)

Behaviour:
- NSLICE = FDATAW/SLICEW (6 at defaults). The FIFO stores {flast, faddr, fdata}.
- Reset (synchronous, rst=1 at a clk edge): FIFO empties (level=0), rd_valid=0, rd_idx=0, done=0, nforce=0, csum=0. fready=1 in the first cycle after reset. rd_slice, rd_addr and rd_last are 0 while empty.
- Reset mid-operation discards all buffered entries and any partially read entry. Nothing is flushed.
- fready = (level < DEPTH), combinational from registered level.
- Push occurs when fvalid && fready. fvalid while !fready is ignored; md_lr_top holds the data.
- Latency: an entry pushed at edge N into an empty FIFO gives rd_valid=1 after edge N (the FIFO is registered, with no fall-through in the push cycle).
- rd_slice = head fdata[rd_idx*SLICEW +: SLICEW]. rd_addr and rd_last come from the head entry.
- slice_ack with rd_valid=1:
  - If rd_idx < NSLICE-1, rd_idx increments.
  - If rd_idx == NSLICE-1, rd_idx returns to 0 and the head entry is popped.
- slice_ack with rd_valid=0 is ignored; rd_idx stays 0.
- Simultaneous push and pop: level is unchanged and both take effect. This holds at full: fready is computed from pre-pop level, so fready=0 at full even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. level is the authoritative full/empty indicator.
- done:
  - Set on the pop of an entry whose flast=1.
  - Cleared by clr_done.
  - If set and clear occur in the same cycle, set wins.
  - done stays set even if further entries arrive.
- nforce:
  - Increments on each push.
  - Saturates at all-ones; it does not wrap.
  - Cleared by clr_done. If clear and push occur in the same cycle, the result is 1.
- No state machine beyond the slice index and FIFO. The FIFO is register-based; no memory macros.

Optional Feature:
- Macro: MD_LR_FORCE_DRAIN_CSUM_EN.
- Defined: csum <= csum ^ fdata on every push. It is cleared by rst and by clr_done; a clear with a simultaneous push gives csum = fdata.
- Undefined: csum is tied to 0 and no checksum register is built.
- All other behaviour is identical in both builds.

Test Plan:
- Single entry: after reset, push faddr=5, fdata=96'h0006_0005_0004_0003_0002_0001, flast=0.
  - Next cycle: rd_valid=1, rd_idx=0, rd_slice=16'h0001.
  - Six slice_acks return slices 1..6; then rd_valid=0, level=0, done=0, nforce=1.
- Fill/backpressure: hold fvalid=1 with no slice_ack, pushing fdata=i for i=0..19.
  - Exactly 16 accepted; fready=0 with level=16.
  - Drain: rd_addr order is 0..15; after the first pop, entry 16 is accepted on the next fvalid.
- Simultaneous push/pop at full: with level=16, pulse the 6th slice_ack while fvalid=1.
  - The push is not accepted that cycle; level=15.
  - Next cycle fready=1 and the push is accepted; level=16.
- Done and clear: push 3 entries, the last with flast=1, and drain them.
  - done=1 after the final pop; nforce=3.
  - Pulse clr_done in the same cycle as a further flast pop: done stays 1.
  - A subsequent lone clr_done gives done=0, nforce=0.
- Reset mid-read: after 2 of 6 slice_acks on the head entry with level=4, assert rst for one cycle.
  - Result: level=0, rd_valid=0, rd_idx=0, done=0, fready=1.
  - slice_ack while empty is ignored.
- Checksum (macro defined): push fdata A=96'hF0F0 and B=96'h0FF0 -> csum=96'hFF00.
  - clr_done together with a push of C gives csum=C.
  - Macro undefined: csum=0 throughout.

Source files
------------

// File: rtl/md_lr_force_drain_if.sv
// Force-drain interface: the force handshake from md_lr_top, the host slice
// read port, and the status/counter outputs of md_lr_force_drain.
// The "slave" modport is the drain block; "master" is whatever drives it
// (md_lr_top plus the CSR path, or a testbench).
interface md_lr_force_drain_if #(
  parameter int PADDRW = 15,
  parameter int FDATAW = 96,
  parameter int SLICEW = 16,
  parameter int DEPTH  = 16
);
  localparam int IDXW = $clog2(FDATAW / SLICEW);
  localparam int LVLW = $clog2(DEPTH) + 1;

  // Force entry handshake from md_lr_top
  logic              fready;
  logic              fvalid;
  logic [PADDRW-1:0] faddr;
  logic              flast;
  logic [FDATAW-1:0] fdata;

  // Host-side slice read port
  logic              rd_valid;
  logic [SLICEW-1:0] rd_slice;
  logic [IDXW-1:0]   rd_idx;
  logic [PADDRW-1:0] rd_addr;
  logic              rd_last;
  logic              slice_ack;

  // Status / bookkeeping
  logic              clr_done;
  logic              done;
  logic [PADDRW:0]   nforce;
  logic [LVLW-1:0]   level;
  logic [FDATAW-1:0] csum;

  modport slave (
    output fready,
    input  fvalid, faddr, flast, fdata,
    output rd_valid, rd_slice, rd_idx, rd_addr, rd_last,
    input  slice_ack, clr_done,
    output done, nforce, level, csum
  );

  modport master (
    input  fready,
    output fvalid, faddr, flast, fdata,
    input  rd_valid, rd_slice, rd_idx, rd_addr, rd_last,
    output slice_ack, clr_done,
    input  done, nforce, level, csum
  );
endinterface

// File: rtl/md_lr_force_drain.sv
// md_lr_force_drain: buffers force results from md_lr_top in a register FIFO
// and hands each FDATAW-bit entry to the host as SLICEW-bit slices, one per
// slice_ack. Tracks completion (done) and the number of accepted forces.
// Optional: define MD_LR_FORCE_DRAIN_CSUM_EN to build the running XOR
// checksum of accepted fdata on csum; otherwise csum is tied to 0.
module md_lr_force_drain #(
  parameter int PADDRW = 15,
  parameter int FDATAW = 96,
  parameter int SLICEW = 16,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst,
  md_lr_force_drain_if.slave  bus
);

  localparam int NSLICE = FDATAW / SLICEW;
  localparam int IDXW   = $clog2(NSLICE);
  localparam int PTRW   = $clog2(DEPTH);
  localparam int LVLW   = PTRW + 1;

  typedef struct packed {
    logic              last;
    logic [PADDRW-1:0] addr;
    logic [FDATAW-1:0] data;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTRW-1:0]   r_wr_ptr;
  logic [PTRW-1:0]   r_rd_ptr;
  logic [LVLW-1:0]   r_level;
  logic [IDXW-1:0]   r_idx;
  logic              r_done;
  logic [PADDRW:0]   r_nforce;

  logic              w_fready;
  logic              w_rd_valid;
  logic              w_push;
  logic              w_ack;
  logic              w_last_slice;
  logic              w_pop;
  entry_t            w_head;
  logic [SLICEW-1:0] w_slice;

  // fready uses the pre-pop level, so a full FIFO refuses a push even in
  // the cycle it pops; the entry is taken one cycle later.
  assign w_fready     = (r_level < LVLW'(DEPTH));
  assign w_rd_valid   = (r_level != '0);
  assign w_push       = bus.fvalid && w_fready;
  assign w_ack        = bus.slice_ack && w_rd_valid;
  assign w_last_slice = (r_idx == IDXW'(NSLICE - 1));
  assign w_pop        = w_ack && w_last_slice;
  assign w_head       = r_mem[r_rd_ptr];

  // Select the slice of the head entry addressed by the slice index
  always_comb begin
    // NOTE: default first so every path assigns w_slice and no latch is inferred.
    w_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (r_idx == IDXW'(i)) w_slice = w_head.data[i*SLICEW +: SLICEW];
    end
  end

  // Entry storage: written on push only
  // NOTE: storage is not reset; contents are only observed while level is
  // non-zero, so stale entries after reset are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{last: bus.flast, addr: bus.faddr, data: bus.fdata};
  end

  // FIFO pointers, occupancy and slice index; reset drops everything buffered
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_idx    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_ack) r_idx <= w_last_slice ? '0 : r_idx + 1'b1;
    end
  end

  // Sticky done flag and saturating accepted-force counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done   <= 1'b0;
      r_nforce <= '0;
    end else begin
      // A last-entry pop in the same cycle as clr_done leaves done set.
      if (w_pop && w_head.last) r_done <= 1'b1;
      else if (bus.clr_done)    r_done <= 1'b0;

      if (bus.clr_done)                  r_nforce <= w_push ? (PADDRW+1)'(1) : '0;
      else if (w_push && ~&r_nforce)     r_nforce <= r_nforce + 1'b1;
    end
  end

`ifdef MD_LR_FORCE_DRAIN_CSUM_EN
  logic [FDATAW-1:0] r_csum;

  // Running XOR of accepted force data; clear with push keeps the new data
  always_ff @(posedge clk) begin
    if (rst)               r_csum <= '0;
    else if (bus.clr_done) r_csum <= w_push ? bus.fdata : '0;
    else if (w_push)       r_csum <= r_csum ^ bus.fdata;
  end

  assign bus.csum = r_csum;
`else
  assign bus.csum = '0;
`endif

  assign bus.fready   = w_fready;
  assign bus.rd_valid = w_rd_valid;
  assign bus.rd_slice = w_rd_valid ? w_slice : '0;
  assign bus.rd_idx   = r_idx;
  assign bus.rd_addr  = w_rd_valid ? w_head.addr : '0;
  assign bus.rd_last  = w_rd_valid && w_head.last;
  assign bus.done     = r_done;
  assign bus.nforce   = r_nforce;
  assign bus.level    = r_level;

endmodule

// File: tb/tb_md_lr_force_drain.sv
// Testbench for md_lr_force_drain: directed stimulus, a queue-based reference
// model checked against every output each cycle, and literal expectations
// for the documented scenarios. Honours MD_LR_FORCE_DRAIN_CSUM_EN.
module tb_md_lr_force_drain;

  localparam int PADDRW = 15;
  localparam int FDATAW = 96;
  localparam int SLICEW = 16;
  localparam int DEPTH  = 16;
  localparam int NSLICE = FDATAW / SLICEW;
  localparam int NFMAX  = (1 << (PADDRW + 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_lr_force_drain_if #(.PADDRW(PADDRW), .FDATAW(FDATAW), .SLICEW(SLICEW), .DEPTH(DEPTH)) bus ();

  md_lr_force_drain #(.PADDRW(PADDRW), .FDATAW(FDATAW), .SLICEW(SLICEW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  typedef struct {
    bit              last;
    bit [PADDRW-1:0] addr;
    bit [FDATAW-1:0] data;
  } ent_t;

  ent_t            q[$];
  int              m_idx    = 0;
  bit              m_done   = 1'b0;
  int              m_nforce = 0;
  bit [FDATAW-1:0] m_csum   = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge worth of behaviour, using the inputs
  // held across that edge and the model state from before it.
  task automatic model_step();
    bit   push;
    ent_t e;
    if (rst) begin
      q.delete();
      m_idx = 0; m_done = 1'b0; m_nforce = 0; m_csum = '0;
      return;
    end
    push = bus.fvalid && (q.size() < DEPTH);
    if (bus.clr_done) begin
      m_done = 1'b0; m_nforce = 0; m_csum = '0;
    end
    if (bus.slice_ack && q.size() > 0) begin
      if (m_idx == NSLICE - 1) begin
        e = q.pop_front();
        m_idx = 0;
        if (e.last) m_done = 1'b1;
      end else begin
        m_idx++;
      end
    end
    if (push) begin
      if (m_nforce < NFMAX) m_nforce++;
`ifdef MD_LR_FORCE_DRAIN_CSUM_EN
      m_csum ^= bus.fdata;
`endif
      e.last = bus.flast; e.addr = bus.faddr; e.data = bus.fdata;
      q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare every DUT output against the model, away from the active edge
  logic [FDATAW-1:0] tmp_data;
  always @(negedge clk) begin
    if (chk_en) begin
      tmp_data = (q.size() > 0) ? (q[0].data >> (m_idx * SLICEW)) : '0;
      check("m.fready",   bus.fready,   q.size() < DEPTH);
      check("m.rd_valid", bus.rd_valid, q.size() > 0);
      check("m.level",    bus.level,    q.size());
      check("m.rd_idx",   bus.rd_idx,   m_idx);
      check("m.rd_slice", bus.rd_slice, tmp_data[SLICEW-1:0]);
      check("m.rd_addr",  bus.rd_addr,  (q.size() > 0) ? q[0].addr : '0);
      check("m.rd_last",  bus.rd_last,  (q.size() > 0) ? q[0].last : 1'b0);
      check("m.done",     bus.done,     m_done);
      check("m.nforce",   bus.nforce,   m_nforce);
      check("m.csum",     bus.csum,     m_csum);
    end
  end

  task automatic push(input int addr, input logic [FDATAW-1:0] data, input bit last);
    bus.fvalid = 1'b1;
    bus.faddr  = PADDRW'(addr);
    bus.fdata  = data;
    bus.flast  = last;
    cyc();
    bus.fvalid = 1'b0;
    bus.flast  = 1'b0;
  endtask

  task automatic ack_n(input int n);
    for (int k = 0; k < n; k++) begin
      bus.slice_ack = 1'b1;
      cyc();
    end
    bus.slice_ack = 1'b0;
  endtask

  logic [FDATAW-1:0] c_val;
  int                n_acc;
  bit                acc;

  initial begin
    bus.fvalid = 1'b0; bus.faddr = '0; bus.flast = 1'b0; bus.fdata = '0;
    bus.slice_ack = 1'b0; bus.clr_done = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst.fready",   bus.fready,   1'b1);
    check("rst.level",    bus.level,    0);
    check("rst.rd_valid", bus.rd_valid, 1'b0);
    check("rst.done",     bus.done,     1'b0);
    check("rst.nforce",   bus.nforce,   0);
    check("rst.rd_slice", bus.rd_slice, 0);

    // Single entry, sliced out one ack at a time
    push(5, 96'h0006_0005_0004_0003_0002_0001, 1'b0);
    check("one.rd_valid", bus.rd_valid, 1'b1);
    check("one.rd_idx",   bus.rd_idx,   0);
    check("one.rd_addr",  bus.rd_addr,  5);
    for (int k = 0; k < NSLICE; k++) begin
      check("one.slice", bus.rd_slice, k + 1);
      ack_n(1);
    end
    check("one.rd_valid_end", bus.rd_valid, 1'b0);
    check("one.level_end",    bus.level,    0);
    check("one.done",         bus.done,     1'b0);
    check("one.nforce",       bus.nforce,   1);

    // Fill with fvalid held high: only DEPTH accepted
    n_acc = 0;
    bus.fvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.fdata = FDATAW'(n_acc);
      bus.faddr = PADDRW'(n_acc);
      acc = bus.fready;
      cyc();
      if (acc) n_acc++;
    end
    check("fill.accepted", n_acc, 16);
    check("fill.fready",   bus.fready, 1'b0);
    check("fill.level",    bus.level,  16);
    check("fill.head",     bus.rd_addr, 0);

    // Pop at full with fvalid still high: push refused this cycle, taken next
    ack_n(NSLICE);
    check("full.level_pop",  bus.level,  15);
    check("full.fready_pop", bus.fready, 1'b1);
    cyc();
    bus.fvalid = 1'b0;
    check("full.level_push",  bus.level,  16);
    check("full.fready_push", bus.fready, 1'b0);

    // Drain: entries come out in push order
    for (int e = 1; e <= 16; e++) begin
      check("drain.order", bus.rd_addr, e);
      ack_n(NSLICE);
    end
    check("drain.level",  bus.level,  0);
    check("drain.nforce", bus.nforce, 18);

    // Done and clear
    bus.clr_done = 1'b1; cyc(); bus.clr_done = 1'b0;
    check("clr.nforce", bus.nforce, 0);
    push(100, 96'hA, 1'b0);
    push(101, 96'hB, 1'b0);
    push(102, 96'hC, 1'b1);
    check("done.pre", bus.done, 1'b0);
    ack_n(3 * NSLICE);
    check("done.set",    bus.done,   1'b1);
    check("done.nforce", bus.nforce, 3);
    bus.clr_done = 1'b1;
    push(103, 96'hD, 1'b1);
    bus.clr_done = 1'b0;
    check("clrpush.nforce", bus.nforce, 1);
    check("clrpush.done",   bus.done,   1'b0);
    ack_n(NSLICE - 1);
    bus.slice_ack = 1'b1; bus.clr_done = 1'b1;
    cyc();
    bus.slice_ack = 1'b0; bus.clr_done = 1'b0;
    check("setwins.done",   bus.done,   1'b1);
    check("setwins.nforce", bus.nforce, 0);
    bus.clr_done = 1'b1; cyc(); bus.clr_done = 1'b0;
    check("lone_clr.done",   bus.done,   1'b0);
    check("lone_clr.nforce", bus.nforce, 0);

    // Reset in the middle of reading an entry
    push(200, 96'h1, 1'b1);
    ack_n(NSLICE);
    check("mid.done_before", bus.done, 1'b1);
    for (int e = 0; e < 4; e++) push(201 + e, FDATAW'(e + 7), 1'b0);
    ack_n(2);
    check("mid.level",  bus.level,  4);
    check("mid.rd_idx", bus.rd_idx, 2);
    rst = 1'b1; cyc(); rst = 1'b0;
    check("mid.level_rst",  bus.level,    0);
    check("mid.valid_rst",  bus.rd_valid, 1'b0);
    check("mid.idx_rst",    bus.rd_idx,   0);
    check("mid.done_rst",   bus.done,     1'b0);
    check("mid.fready_rst", bus.fready,   1'b1);
    ack_n(1);
    check("empty_ack.idx",   bus.rd_idx,   0);
    check("empty_ack.valid", bus.rd_valid, 1'b0);

    // Checksum
    push(300, 96'hF0F0, 1'b0);
    push(301, 96'h0FF0, 1'b0);
`ifdef MD_LR_FORCE_DRAIN_CSUM_EN
    check("csum.ab", bus.csum, 96'hFF00);
`else
    check("csum.ab_off", bus.csum, 0);
`endif
    c_val = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
    bus.clr_done = 1'b1;
    push(302, c_val, 1'b0);
    bus.clr_done = 1'b0;
`ifdef MD_LR_FORCE_DRAIN_CSUM_EN
    check("csum.clr_push", bus.csum, c_val);
`else
    check("csum.clr_push_off", bus.csum, 0);
`endif
    ack_n(3 * NSLICE);
    check("final.level", bus.level, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
